// File: rtl/alu_unit.sv
// Registered execute-stage ALU: one-hot op select, signed 32-bit operands,
// 64-bit result split into HI/LO words, available one clock after the inputs.
module alu_unit #(
   parameter int BITS      = 32,
   parameter int SIG_COUNT = 12
) (
   input  logic                   clk,
   input  logic                   clr,
   input  logic [SIG_COUNT-1:0]   ctrl_signal,
   input  logic signed [BITS-1:0] X,
   input  logic signed [BITS-1:0] Y,
   output logic [BITS-1:0]        OpResult_HI,
   output logic [BITS-1:0]        OpResult_LO
);

   localparam logic [BITS-1:0] MIN_NEG = {1'b1, {(BITS-1){1'b0}}};

   // Divide-by-zero and the single overflowing quotient are mapped to fixed
   // results instead of relying on the operator's undefined behaviour.
   function automatic logic [2*BITS-1:0] div_rem(input logic signed [BITS-1:0] a,
                                                  input logic signed [BITS-1:0] b);
      logic signed [BITS-1:0] q;
      logic signed [BITS-1:0] r;
      if (b == '0) begin
         q = '1;
         r = a;
      end else if (a == MIN_NEG && b == '1) begin
         q = MIN_NEG;
         r = '0;
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   logic [4:0]              amt;
   logic signed [2*BITS-1:0] prod;
   logic [2*BITS-1:0]       quo_rem;
   logic [BITS-1:0]         ux;
   logic [BITS-1:0]         hi_d, lo_d;
   logic [BITS-1:0]         hi_q, lo_q;

   assign amt     = Y[4:0];
   assign ux      = $unsigned(X);
   assign prod    = X * Y;
   assign quo_rem = div_rem(X, Y);

   // Lowest-index set bit has priority.
   always_comb begin
      hi_d = '0;
      lo_d = '0;
      if (ctrl_signal[0]) begin
         lo_d = X + Y;
      end else if (ctrl_signal[1]) begin
         lo_d = X - Y;
      end else if (ctrl_signal[2]) begin
         hi_d = prod[2*BITS-1:BITS];
         lo_d = prod[BITS-1:0];
      end else if (ctrl_signal[3]) begin
         hi_d = quo_rem[2*BITS-1:BITS];
         lo_d = quo_rem[BITS-1:0];
      end else if (ctrl_signal[4]) begin
         lo_d = ux >> amt;
      end else if (ctrl_signal[5]) begin
         lo_d = ux << amt;
      end else if (ctrl_signal[6]) begin
         lo_d = (ux >> amt) | (ux << (BITS - int'(amt)));
      end else if (ctrl_signal[7]) begin
         lo_d = (ux << amt) | (ux >> (BITS - int'(amt)));
      end else if (ctrl_signal[8]) begin
         lo_d = X & Y;
      end else if (ctrl_signal[9]) begin
         lo_d = X | Y;
      end else if (ctrl_signal[10]) begin
         lo_d = -X;
      end else if (ctrl_signal[11]) begin
         lo_d = ~X;
      end
   end

   // Output register stage
   always_ff @(posedge clk) begin
      if (clr) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign OpResult_HI = hi_q;
   assign OpResult_LO = lo_q;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vector table, hand-written
// timing sequences and randomized checks against an arithmetic model.
module tb_alu_unit;

   localparam logic [11:0] OP_ADD = 12'h001, OP_SUB = 12'h002, OP_MUL = 12'h004,
                           OP_DIV = 12'h008, OP_SHR = 12'h010, OP_SHL = 12'h020,
                           OP_ROR = 12'h040, OP_ROL = 12'h080, OP_AND = 12'h100,
                           OP_OR  = 12'h200, OP_NEG = 12'h400, OP_NOT = 12'h800;

   logic               clk = 1'b0;
   logic               clr;
   logic [11:0]        ctrl_signal;
   logic signed [31:0] X, Y;
   logic [31:0]        OpResult_HI, OpResult_LO;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [11:0] ctrl;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[$];

   alu_unit #(.BITS(32), .SIG_COUNT(12)) dut (
      .clk         (clk),
      .clr         (clr),
      .ctrl_signal (ctrl_signal),
      .X           (X),
      .Y           (Y),
      .OpResult_HI (OpResult_HI),
      .OpResult_LO (OpResult_LO)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] hi_exp, input logic [31:0] lo_exp);
      checks++;
      if (OpResult_HI !== hi_exp || OpResult_LO !== lo_exp) begin
         failures++;
         $display("FAIL %s: got HI=%08h LO=%08h, expected HI=%08h LO=%08h (ctrl=%03h X=%08h Y=%08h)",
                  name, OpResult_HI, OpResult_LO, hi_exp, lo_exp, ctrl_signal, X, Y);
      end
   endtask

   task automatic add(input logic [11:0] c, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] hi, input logic [31:0] lo);
      vec_t v;
      v.ctrl = c; v.x = x; v.y = y; v.hi = hi; v.lo = lo;
      vecs.push_back(v);
   endtask

   // Drive inputs just after an edge, then sample 1 time unit after the next edge.
   task automatic apply(input logic [11:0] c, input logic [31:0] x, input logic [31:0] y);
      ctrl_signal = c;
      X = x;
      Y = y;
      @(posedge clk);
      #1;
   endtask

   function automatic longint pow2(input int n);
      longint p = 1;
      for (int i = 0; i < n; i++) p = p * 2;
      return p;
   endfunction

   // Reference model built from plain integer arithmetic on 64-bit values.
   task automatic model(input logic [11:0] c, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] hi, output logic [31:0] lo);
      longint a  = longint'($signed(x));
      longint b  = longint'($signed(y));
      longint ua = longint'(x);
      longint m  = pow2(32);
      int     n  = int'(y % 32);
      int     k  = -1;
      longint v;
      for (int i = 11; i >= 0; i--) if (c[i]) k = i;
      hi = 32'h0;
      lo = 32'h0;
      case (k)
         0: lo = 32'(a + b);
         1: lo = 32'(a - b);
         2: begin v = a * b; hi = 32'(v / m - ((v < 0 && v % m != 0) ? 1 : 0)); lo = 32'(v); end
         3: begin
            if (b == 0) begin lo = 32'hFFFF_FFFF; hi = x; end
            else if (a == -pow2(31) && b == -1) begin lo = 32'h8000_0000; hi = 0; end
            else begin lo = 32'(a / b); hi = 32'(a - (a / b) * b); end
         end
         4: lo = 32'(ua / pow2(n));
         5: lo = 32'((ua * pow2(n)) % m);
         6: begin v = ua; for (int i = 0; i < n; i++) v = v / 2 + (v % 2) * pow2(31); lo = 32'(v); end
         7: begin v = ua; for (int i = 0; i < n; i++) v = (v * 2) % m + v / pow2(31); lo = 32'(v); end
         8: lo = x & y;
         9: lo = x | y;
         10: lo = 32'(-a);
         11: lo = 32'(m - 1 - ua);
         default: ;
      endcase
   endtask

   initial begin
      logic [31:0] ehi, elo, rx, ry;
      logic [11:0] rc;

      add(OP_ADD, 15, 5, 0, 20);
      add(OP_ADD, -15, 5, 0, 32'hFFFF_FFF6);
      add(OP_ADD, 15, -5, 0, 10);
      add(OP_ADD, -15, -5, 0, 32'hFFFF_FFEC);
      add(OP_SUB, 15, 5, 0, 10);
      add(OP_SUB, -15, 5, 0, 32'hFFFF_FFEC);
      add(OP_SUB, 15, -5, 0, 20);
      add(OP_SUB, -15, -5, 0, 32'hFFFF_FFF6);
      add(OP_MUL, 15, 5, 0, 75);
      add(OP_MUL, -15, 5, 32'hFFFF_FFFF, 32'hFFFF_FFB5);
      add(OP_MUL, 15, -5, 32'hFFFF_FFFF, 32'hFFFF_FFB5);
      add(OP_MUL, -15, -5, 0, 75);
      add(OP_MUL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
      add(OP_DIV, 15, 5, 0, 3);
      add(OP_DIV, -15, 5, 0, 32'hFFFF_FFFD);
      add(OP_DIV, 15, -5, 0, 32'hFFFF_FFFD);
      add(OP_DIV, -15, -5, 0, 3);
      add(OP_DIV, 17, 5, 2, 3);
      add(OP_DIV, -17, 5, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
      add(OP_DIV, 15, 0, 15, 32'hFFFF_FFFF);
      add(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
      add(OP_SHR, 16, 2, 0, 4);
      add(OP_SHL, 16, 2, 0, 64);
      add(OP_ROR, 2, 2, 0, 32'h8000_0000);
      add(OP_ROL, 32'h8000_0000, 2, 0, 2);
      add(OP_SHR, 32'h8000_0000, 31, 0, 1);
      add(OP_SHR, 16, 32, 0, 16);
      add(OP_SHL, 16, 32, 0, 16);
      add(OP_ROR, 32'h1234_5678, 32, 0, 32'h1234_5678);
      add(OP_ROL, 32'h1234_5678, 4, 0, 32'h2345_6781);
      add(OP_AND, 15, 0, 0, 0);
      add(OP_OR, 15, 0, 0, 15);
      add(OP_NEG, 15, 0, 0, 32'hFFFF_FFF1);
      add(OP_NOT, 15, 0, 0, 32'hFFFF_FFF0);
      add(OP_NEG, 15, 7, 0, 32'hFFFF_FFF1);
      add(12'h000, 15, 5, 0, 0);
      add(OP_ADD | OP_MUL, 15, 5, 0, 20);
      add(OP_MUL | OP_NOT, 15, 5, 0, 75);
      add(OP_AND | OP_OR, 12, 10, 0, 8);

      // Reset behaviour
      clr = 1'b1;
      apply(OP_ADD, 15, 5);
      check("reset_hold", 0, 0);
      clr = 1'b0;
      @(posedge clk); #1;
      check("reset_release", 0, 20);

      foreach (vecs[i]) begin
         apply(vecs[i].ctrl, vecs[i].x, vecs[i].y);
         check($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
      end

      // Inputs changed between edges do not reach the outputs early
      apply(OP_ADD, 15, 5);
      check("mid_before", 0, 20);
      X = 100;
      ctrl_signal = OP_MUL;
      #2;
      check("mid_hold", 0, 20);
      @(posedge clk); #1;
      check("mid_after", 0, 500);

      // clr overrides a live operation, then results resume
      clr = 1'b1;
      apply(OP_MUL, -15, 5);
      check("clr_override", 0, 0);
      clr = 1'b0;
      @(posedge clk); #1;
      check("clr_resume", 32'hFFFF_FFFF, 32'hFFFF_FFB5);

      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5, 6: rc = 12'(1 << $urandom_range(0, 11));
            7, 8:                rc = 12'($urandom_range(0, 4095));
            default:             rc = 12'h000;
         endcase
         case ($urandom_range(0, 7))
            0:       rx = 32'h8000_0000;
            1:       rx = 32'hFFFF_FFFF;
            2:       rx = 32'($urandom_range(0, 40)) - 20;
            default: rx = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0:       ry = 0;
            1:       ry = 32'hFFFF_FFFF;
            2:       ry = 32'($urandom_range(0, 40)) - 20;
            default: ry = $urandom;
         endcase
         model(rc, rx, ry, ehi, elo);
         apply(rc, rx, ry);
         check($sformatf("rand%0d", i), ehi, elo);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_unit.md
# alu_unit

Registered 32-bit integer ALU for the datapath's execute stage. It is selected by a 12-bit one-hot operation code. It computes arithmetic, shift, rotate and logic results on two signed 32-bit operands. It delivers a 64-bit result split into HI and LO words one clock after the operands are presented.

## Interface
- BITS, 32, operand and result-word width
- SIG_COUNT, 12, width of one-hot operation select
- clk  input  1  rising-edge clock
- clr  input  1  reset; one clock; reset is synchronous and active-high
- ctrl_signal  input  SIG_COUNT  one-hot operation select
- X  input  BITS  signed operand A
- Y  input  BITS  signed operand B; shift/rotate amount in Y[4:0]
- OpResult_HI  output  BITS  registered upper result word
- OpResult_LO  output  BITS  registered lower result word

## Operation
- ctrl_signal bit assignment: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SHR, 5 SHL, 6 ROR, 7 ROL, 8 AND, 9 OR, 10 NEG, 11 NOT.
- ADD: LO = X+Y mod 2^32, HI = 0. No carry/overflow flag.
- SUB: LO = X−Y mod 2^32, HI = 0.
- MUL: signed 32×32 → 64-bit product; HI = bits 63:32, LO = bits 31:0.
- DIV: signed, truncates toward zero.
  - LO = quotient; HI = remainder, which takes the sign of X.
  - Y = 0: LO = 32'hFFFFFFFF, HI = X.
  - X = −2^31, Y = −1: LO = 32'h80000000, HI = 0.
- SHR: logical right shift of X by Y[4:0], zero fill; HI = 0.
- SHL: left shift of X by Y[4:0], zero fill; HI = 0.
- ROR / ROL: rotate X right/left by Y[4:0]; HI = 0. An amount of 0 returns X.
- AND / OR: bitwise X&Y, X|Y; HI = 0.
- NEG: LO = −X (two's complement); HI = 0. Y is ignored.
- NOT: LO = ~X; HI = 0. Y is ignored.
- ctrl_signal all zero: HI = LO = 0.
- Multiple bits set: the lowest-index set bit wins.
- The result is purely a function of the current inputs. There is no accumulation or state beyond the output registers.

## Timing
- Single-cycle latency. Inputs sampled at rising edge N appear on OpResult_HI/LO after edge N and hold until edge N+1.
- The result is computed combinationally within one cycle, including MUL and DIV. There is no multi-cycle handshake, busy or valid signal.
- clr high at a rising edge sets both outputs to 0 on that edge, overriding any operation.
- When clr is deasserted, the first result appears one edge later.
- Outputs are 0 after reset until the first non-reset edge.
- Changing ctrl_signal or operands between edges has no effect on outputs until the next edge.

## Test plan
- Reset: clr=1 for one edge with ctrl=ADD, X=15, Y=5 -> HI=LO=0. Release clr -> next edge LO=20, HI=0.
- ADD/SUB sweep with (X,Y) = (15,5), (−15,5), (15,−5), (−15,−5):
  - ADD LO = 20, −10, 10, −20.
  - SUB LO = 10, −20, 20, −10.
- MUL/DIV sweep over the same pairs:
  - MUL {HI,LO} = 75, −75 (HI=FFFFFFFF, LO=FFFFFFB5), −75, 75.
  - DIV LO = 3, −3, −3, 3 with HI=0. X=17, Y=5 -> LO=3, HI=2. X=−17, Y=5 -> LO=−3, HI=−2. Y=0 -> LO=FFFFFFFF, HI=X.
- Shift/rotate:
  - SHR 16 by 2 -> 4.
  - SHL 16 by 2 -> 64.
  - ROR 2 by 2 -> 80000000.
  - ROL 80000000 by 2 -> 00000002.
  - SHR 80000000 by 31 -> 1.
  - Shift by Y=32 -> uses Y[4:0]=0 -> X unchanged.
- Logic/unary with X=15, Y=0:
  - AND -> 0.
  - OR -> 15.
  - NEG -> FFFFFFF1.
  - NOT -> FFFFFFF0.
  - HI=0 in all four.
- Select edge cases: ctrl=0 -> 0/0. ctrl = ADD|MUL with X=15, Y=5 -> ADD result 20. Operands changed mid-cycle -> output updates only at the next edge.
